// File: rtl/addsub_arb.sv
// Two-requester arbiter sharing one 8-bit add/sub unit; ADDSUB_ARB_RR_EN selects round-robin, else fixed priority (req0).
// Latency: ready pulse in cycle T, rsp_valid in T+2; one operation in flight, issue interval >= 3 cycles.
// Backpressure: response held in RESP until rsp_ready; requesters wait (ready=0) outside IDLE.

module addsub (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       addnsub_i,
    output logic [8:0] result_o
);
    // Ninth bit of the 9-bit difference is the borrow, i.e. a < b.
    always_comb begin
        if (addnsub_i) begin
            result_o = {1'b0, a_i} + {1'b0, b_i};
        end else begin
            result_o = {1'b0, a_i} - {1'b0, b_i};
        end
    end
endmodule

module addsub_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_addnsub,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_addnsub,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [8:0] rsp_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       op_add_q, op_add_d;
    logic       op_id_q, op_id_d;
    logic [8:0] rsp_result_q, rsp_result_d;
    logic       rsp_id_q, rsp_id_d;
    logic [8:0] alu_result;
    logic       take;
    logic       win1;

    addsub u_addsub (
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .addnsub_i (op_add_q),
        .result_o  (alu_result)
    );

`ifdef ADDSUB_ARB_RR_EN
    // last_q = id of the most recent grant; the other requester wins a tie.
    logic last_q, last_d;

    always_comb begin
        win1 = req1_valid & (~req0_valid | ~last_q);
    end
`else
    always_comb begin
        win1 = req1_valid & ~req0_valid;
    end
`endif

    // Grant is gated by rst_n so no pulse escapes while reset is asserted.
    always_comb begin
        take       = rst_n & (state_q == IDLE) & (req0_valid | req1_valid);
        req0_ready = take & ~win1;
        req1_ready = take & win1;
        rsp_valid  = (state_q == RESP);
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
    end

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_add_d     = op_add_q;
        op_id_d      = op_id_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
`ifdef ADDSUB_ARB_RR_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    op_a_d   = win1 ? req1_a       : req0_a;
                    op_b_d   = win1 ? req1_b       : req0_b;
                    op_add_d = win1 ? req1_addnsub : req0_addnsub;
                    op_id_d  = win1;
`ifdef ADDSUB_ARB_RR_EN
                    last_d   = win1;
`endif
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_id_d     = op_id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= 8'd0;
            op_b_q       <= 8'd0;
            op_add_q     <= 1'b0;
            op_id_q      <= 1'b0;
            rsp_result_q <= 9'd0;
            rsp_id_q     <= 1'b0;
`ifdef ADDSUB_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_add_q     <= op_add_d;
            op_id_q      <= op_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
`ifdef ADDSUB_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_addsub_arb.sv
// Scoreboard bench for addsub_arb: directed operations push expected {id,result}; a monitor pops on each handshake.
module tb_addsub_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_addnsub;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_addnsub;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [8:0] rsp_result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    addsub_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_addnsub (req0_addnsub),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_addnsub (req1_addnsub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id=%0d result=0x%0h with nothing expected", rsp_id, rsp_result);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[9]});
                chk("rsp_result", {23'd0, rsp_result}, {23'd0, e[8:0]});
            end
        end
        if (req0_ready === 1'b1 || req1_ready === 1'b1)
            chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic add);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_addnsub = add;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_addnsub = add;
        end
    endtask

    task automatic wait_grant(input int budget, output int who);
        who = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1) begin who = 0; break; end
            if (req1_ready === 1'b1) begin who = 1; break; end
        end
        if (who < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: got no ready within %0d cycles", budget);
        end
    endtask

    // Single operation with latency check; returns one cycle into the next IDLE.
    task automatic do_single(input string name, input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic add, input logic [8:0] exp);
        int who;
        set_req(id, 1'b1, a, b, add);
        wait_grant(20, who);
        chk({name, "_grant"}, who, id);
        if (who == id) exp_q.push_back({id[0], exp});
        step();
        set_req(id, 1'b0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk({name, "_valid_T1"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_valid_T2"}, {31'd0, rsp_valid}, 32'd1);
        step();
    endtask

    logic [7:0] c0a[4], c0b[4], c1a[4], c1b[4];
    logic       c0s[4], c1s[4];
    logic [8:0] c0r[4], c1r[4];
    int         ord[4];

    initial begin
        int who, i0, i1;
        c0a = '{8'd1,   8'd50,  8'd255, 8'd0};
        c0b = '{8'd2,   8'd60,  8'd1,   8'd0};
        c0s = '{1'b1,   1'b0,   1'b1,   1'b0};
        c0r = '{9'h003, 9'h1F6, 9'h100, 9'h000};
        c1a = '{8'd7,   8'd100, 8'd255, 8'd0};
        c1b = '{8'd3,   8'd27,  8'd255, 8'd1};
        c1s = '{1'b0,   1'b1,   1'b1,   1'b0};
        c1r = '{9'h004, 9'h07F, 9'h1FE, 9'h1FF};
`ifdef ADDSUB_ARB_RR_EN
        ord = '{0, 1, 0, 1};
`else
        ord = '{0, 0, 0, 0};
`endif
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, 8'd0, 8'd0, 1'b0);
        set_req(1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", {23'd0, rsp_result}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        do_single("add_carry", 0, 8'd200, 8'd100, 1'b1, 9'h12C);
        do_single("sub_borrow", 1, 8'd5, 8'd10, 1'b0, 9'h1FB);
        do_single("sub_plain", 1, 8'd10, 8'd5, 1'b0, 9'h005);

        // Contention: both held valid across four grants.
        i0 = 0; i1 = 0;
        set_req(0, 1'b1, c0a[0], c0b[0], c0s[0]);
        set_req(1, 1'b1, c1a[0], c1b[0], c1s[0]);
        for (int g = 0; g < 4; g++) begin
            wait_grant(20, who);
            if (who < 0) break;
            chk("contend_order", who, ord[g]);
            if (who == 0) begin exp_q.push_back({1'b0, c0r[i0]}); i0++; end
            else          begin exp_q.push_back({1'b1, c1r[i1]}); i1++; end
            step();
            if (g < 3) begin
                if (who == 0) set_req(0, 1'b1, c0a[i0], c0b[i0], c0s[i0]);
                else          set_req(1, 1'b1, c1a[i1], c1b[i1], c1s[i1]);
            end else begin
                set_req(0, 1'b0, 8'd0, 8'd0, 1'b0);
                set_req(1, 1'b0, 8'd0, 8'd0, 1'b0);
            end
        end
        repeat (2) step();

        // Backpressure: response stalled while req1 waits.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'd20, 8'd22, 1'b1);
        wait_grant(20, who);
        chk("bp_grant", who, 0);
        exp_q.push_back({1'b0, 9'h02A});
        step();
        set_req(0, 1'b0, 8'd0, 8'd0, 1'b0);
        set_req(1, 1'b1, 8'd9, 8'd4, 1'b0);
        @(negedge clk);
        chk("bp_exec_no_ready", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", {23'd0, rsp_result}, 32'h02A);
            chk("bp_hold_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_hold_no_ready", {31'd0, req1_ready}, 32'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_no_ready", {31'd0, req1_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("bp_next_grant", {31'd0, req1_ready}, 32'd1);
        if (req1_ready === 1'b1) exp_q.push_back({1'b1, 9'h005});
        step();
        set_req(1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (2) step();

        // Reset during EXEC: op discarded, pointer returns to favour req0.
        set_req(0, 1'b1, 8'd3, 8'd4, 1'b1);
        wait_grant(20, who);
        chk("rstmid_grant", who, 0);
        step();
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'd3, 8'd4, 1'b1);
        set_req(1, 1'b1, 8'd1, 8'd1, 1'b1);
        step();
        @(negedge clk);
        chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rstmid_rsp_result", {23'd0, rsp_result}, 32'd0);
        chk("rstmid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        wait_grant(20, who);
        chk("rstmid_first_grant", who, 0);
        if (who == 0) exp_q.push_back({1'b0, 9'h007});
        step();
        set_req(0, 1'b0, 8'd0, 8'd0, 1'b0);
        set_req(1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) step();

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
